valid_ready_stack: RTL and testbench

Synchronous last-in first-out stack with valid-ready flow control on both sides, a fill-level output, almost-full/almost-empty flags, a synchronous flush, and same-cycle push+pop. Storage is an internal circular register array, so the top entry is always read from flops with no RAM latency. It sits between a producer and a consumer that need most-recent-first ordering, such as return-address stacks, undo buffers, and depth-first work queues. An optional overwrite mode turns it into a bounded history that drops the oldest entry when full.

---
 rtl/valid_ready_stack.sv | 106 ++++++++++
 tb/tb_valid_ready_stack.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/valid_ready_stack.sv
// LIFO stack with valid/ready on both sides, fill-level and almost flags, flush and push+pop replace.
// Define VALID_READY_STACK_OVERWRITE_EN to turn it into a bounded history that drops the oldest entry when full.
module valid_ready_stack #(
  parameter int WIDTH              = 8,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       dropped,
  input  logic [WIDTH-1:0]           write_data,
  input  logic                       write_valid,
  output logic                       write_ready,
  output logic [WIDTH-1:0]           read_data,
  output logic                       read_valid,
  input  logic                       read_ready
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] TOP_MAX  = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH);
  localparam logic [31:0]      AF_LEVEL = ALMOST_FULL_LEVEL;
  localparam logic [31:0]      AE_LEVEL = ALMOST_EMPTY_LEVEL;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic [PTR_W-1:0] wr_idx;
  logic [31:0]      level_ext;
  logic             push;
  logic             pop;

  // Explicit compare-and-wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == TOP_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? TOP_MAX : p - PTR_W'(1);
  endfunction

  assign top_inc   = ptr_inc(top);
  assign top_dec   = ptr_dec(top);
  assign level_ext = 32'(level);

  assign full         = (level == LVL_MAX);
  assign empty        = (level == '0);
  assign almost_full  = (level_ext >= AF_LEVEL);
  assign almost_empty = (level_ext <= AE_LEVEL);

  assign read_valid = ~empty;
  assign read_data  = mem[top];

`ifdef VALID_READY_STACK_OVERWRITE_EN
  assign write_ready = 1'b1;
`else
  assign write_ready = ~full;
`endif

  assign push = write_valid & write_ready;
  assign pop  = read_valid & read_ready;

  // Control state: top pointer and fill level
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      top   <= '0;
      level <= '0;
    end else if (flush) begin
      top   <= '0;
      level <= '0;
    end else if (push && !pop) begin
      top <= top_inc;
      // A push while full only happens in overwrite mode; level saturates at DEPTH.
      if (!full) level <= level + LVL_W'(1);
    end else if (pop && !push) begin
      top   <= top_dec;
      level <= level - LVL_W'(1);
    end
  end

`ifdef VALID_READY_STACK_OVERWRITE_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) dropped <= 1'b0;
    else         dropped <= ~flush & push & ~pop & full;
  end
`else
  assign dropped = 1'b0;
`endif

  // Storage: push+pop replaces the top in place, plain push writes the slot above it
  assign wr_idx = pop ? top : top_inc;

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_idx] <= write_data;
  end

endmodule

// File: tb/tb_valid_ready_stack.sv
// Randomized and directed bench for valid_ready_stack against a queue-based LIFO model.
// Honours VALID_READY_STACK_OVERWRITE_EN in the model when defined.
module tb_valid_ready_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFL   = DEPTH - 1;
  localparam int AEL   = 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
`ifdef VALID_READY_STACK_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             resetn = 1'b1;
  logic             flush = 1'b0;
  logic             full, empty, almost_full, almost_empty, dropped;
  logic [LVL_W-1:0] level;
  logic [WIDTH-1:0] write_data = '0;
  logic             write_valid = 1'b0;
  logic             write_ready;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             read_ready = 1'b0;

  int compared   = 0;
  int mismatched = 0;
  bit chk_on     = 1'b0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] pops[$];
  bit               exp_dropped = 1'b0;
  int               drops = 0;

  valid_ready_stack #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
  ) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level), .dropped(dropped),
    .write_data(write_data), .write_valid(write_valid), .write_ready(write_ready),
    .read_data(read_data), .read_valid(read_valid), .read_ready(read_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    int n;
    if (chk_on) begin
      n = q.size();
      check("level", 32'(level), 32'(n));
      check("full", 32'(full), 32'(n == DEPTH));
      check("empty", 32'(empty), 32'(n == 0));
      check("almost_full", 32'(almost_full), 32'(n >= AFL));
      check("almost_empty", 32'(almost_empty), 32'(n <= AEL));
      check("read_valid", 32'(read_valid), 32'(n > 0));
      check("write_ready", 32'(write_ready), 32'(OVW || n < DEPTH));
      check("dropped", 32'(dropped), 32'(exp_dropped));
      if (n > 0) check("read_data", 32'(read_data), 32'(q[n-1]));
    end
  end

  // Drive one cycle of inputs, then apply the LIFO rules to the model at the edge.
  task automatic cycle(input bit wv, input logic [WIDTH-1:0] wd, input bit rr, input bit fl);
    bit do_push, do_pop;
    write_valid = wv;
    write_data  = wd;
    read_ready  = rr;
    flush       = fl;
    @(posedge clock);
    if (resetn) begin
      do_push = wv && (OVW || q.size() < DEPTH);
      do_pop  = rr && (q.size() > 0);
      exp_dropped = 1'b0;
      if (fl) begin
        q.delete();
      end else if (do_push && do_pop) begin
        pops.push_back(q[q.size()-1]);
        q[q.size()-1] = wd;
      end else if (do_push) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          exp_dropped = 1'b1;
          drops++;
        end
        q.push_back(wd);
      end else if (do_pop) begin
        pops.push_back(q.pop_back());
      end
    end
    #1;
    write_valid = 1'b0;
    read_ready  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] vals[3];
    int               lv[6];
    int               dut_drops;
    int               wv_pct, rr_pct;
    vals = '{8'h11, 8'h22, 8'h33};
    lv   = '{1, 2, 3, 2, 1, 0};

    #1 resetn = 1'b0;
    chk_on = 1'b1;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_read_valid", 32'(read_valid), 32'd0);
    check("rst_write_ready", 32'(write_ready), 32'd1);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    check("rst_almost_full", 32'(almost_full), 32'(AFL == 0));
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;

    // LIFO order with level trace
    pops.delete();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cycle(1'b1, vals[i], 1'b0, 1'b0);
      else       cycle(1'b0, '0, 1'b1, 1'b0);
      check("t1_level", 32'(level), 32'(lv[i]));
    end
    check("t1_pop_count", 32'(pops.size()), 32'd3);
    if (pops.size() == 3) begin
      check("t1_pop0", 32'(pops[0]), 32'h33);
      check("t1_pop1", 32'(pops[1]), 32'h22);
      check("t1_pop2", 32'(pops[2]), 32'h11);
    end
    check("t1_empty", 32'(empty), 32'd1);

`ifndef VALID_READY_STACK_OVERWRITE_EN
    // Fill to capacity, push is held off
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    check("t2_full", 32'(full), 32'd1);
    check("t2_write_ready", 32'(write_ready), 32'd0);
    cycle(1'b1, 8'hC4, 1'b0, 1'b0);
    check("t2_level_held", 32'(level), 32'd4);
    check("t2_top_held", 32'(read_data), 32'hC3);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t2_ready_after_pop", 32'(write_ready), 32'd1);
    check("t2_next_top", 32'(read_data), 32'hC2);
    drain();
`else
    // Overwrite history: oldest entries dropped, pointer wraps
    dut_drops = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      dut_drops += int'(dropped);
    end
    check("t4_model_drops", 32'(drops), 32'd2);
    check("t4_dut_drops", 32'(dut_drops), 32'd2);
    pops.delete();
    drain();
    check("t4_pop_count", 32'(pops.size()), 32'd4);
    if (pops.size() == 4) begin
      check("t4_pop0", 32'(pops[0]), 32'd6);
      check("t4_pop1", 32'(pops[1]), 32'd5);
      check("t4_pop2", 32'(pops[2]), 32'd4);
      check("t4_pop3", 32'(pops[3]), 32'd3);
    end
`endif

    // Push and pop together replace the top in place
    cycle(1'b1, 8'hA0, 1'b0, 1'b0);
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    pops.delete();
    cycle(1'b1, 8'hB0, 1'b1, 1'b0);
    check("t3_consumed", 32'(pops.size() > 0 ? pops[0] : 8'h00), 32'hA1);
    check("t3_new_top", 32'(read_data), 32'hB0);
    check("t3_level", 32'(level), 32'd2);
    drain();
    check("t3_order", 32'(pops.size() == 3 ? pops[2] : 8'h00), 32'hA0);

    // Flush overrides a simultaneous push
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hD3, 1'b0, 1'b1);
    check("t5_level", 32'(level), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_almost_empty", 32'(almost_empty), 32'd1);
    pops.delete();
    cycle(1'b1, 8'hE0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t5_after_flush", 32'(pops.size() == 1 ? pops[0] : 8'h00), 32'hE0);

    // Asynchronous reset in the middle of a push burst
    cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    cycle(1'b1, 8'hF1, 1'b0, 1'b0);
    write_valid = 1'b1;
    write_data  = 8'hF2;
    #2 resetn = 1'b0;
    q.delete();
    exp_dropped = 1'b0;
    #1;
    check("t6_level", 32'(level), 32'd0);
    check("t6_read_valid", 32'(read_valid), 32'd0);
    check("t6_write_ready", 32'(write_ready), 32'd1);
    write_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    check("t6_first_push", 32'(read_data), 32'h5A);
    check("t6_first_level", 32'(level), 32'd1);
    drain();

    // Random traffic with shifting bias to visit full, empty and wrap
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) begin
        wv_pct = $urandom_range(20, 85);
        rr_pct = $urandom_range(20, 85);
      end
      cycle(($urandom % 100) < wv_pct, 8'($urandom), ($urandom % 100) < rr_pct,
            ($urandom % 80) == 0);
    end
    drain();
    check("final_empty", 32'(empty), 32'd1);

    @(negedge clock);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
